// File: rtl/smart_cargo_movimento_n.sv
// SmartCargo movement controller for N_ANDARES floors: SCAN scheduling over
// separate load/unload request bitmaps, timed dwell, homing and emergency stop.
module smart_cargo_movimento_n #(
    parameter int N_ANDARES = 8,
    parameter int W         = $clog2(N_ANDARES),
    parameter int T_ESPERA  = 50_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 emergencia,
    input  logic [N_ANDARES-1:0] sensores,
    input  logic                 req_valid,
    input  logic [W-1:0]         req_andar,
    input  logic                 req_carga,
    output logic                 motor_subindo,
    output logic                 motor_descendo,
    output logic                 coloca_objetos,
    output logic                 tira_objetos,
    output logic [W-1:0]         andar_atual,
    output logic [W-1:0]         prox_parada,
    output logic                 tem_destino,
    output logic                 req_erro,
    output logic                 sensor_erro,
    output logic [2:0]           estado_db
);

    localparam int                   CW      = (T_ESPERA > 1) ? $clog2(T_ESPERA) : 1;
    localparam logic [CW-1:0]        CNT_ULT = CW'(T_ESPERA - 1);
    localparam logic [W-1:0]         TOPO    = W'(N_ANDARES - 1);
    localparam logic [N_ANDARES-1:0] UM      = N_ANDARES'(1);

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        HOMING     = 3'd1,
        PARADO     = 3'd2,
        SUBINDO    = 3'd3,
        DESCENDO   = 3'd4,
        ESPERA     = 3'd5,
        EMERGENCIA = 3'd6
    } estado_t;

    estado_t                estado_q;
    logic [N_ANDARES-1:0]   s1_q, s2_q, s3_q;
    logic [N_ANDARES-1:0]   pend_coloca_q, pend_tira_q;
    logic [N_ANDARES-1:0]   pend_coloca_d, pend_tira_d;
    logic [W-1:0]           andar_q;
    logic                   sentido_q;
    logic [CW-1:0]          cnt_q;
    logic                   req_erro_q, sensor_erro_q;

    logic [N_ANDARES-1:0]   pend, aqui_sel, req_sel, acima, abaixo, borda;
    logic                   req_ok, req_ruim, s2_multi, s2_um, borda_ok;
    logic                   pend_aqui, pend_borda, tem_acima, tem_abaixo, fim_espera;
    logic [W-1:0]           andar_borda, prox_acima, prox_abaixo, prox;

    always_comb begin
        pend        = pend_coloca_q | pend_tira_q;
        aqui_sel    = '0;
        req_sel     = '0;
        acima       = '0;
        abaixo      = '0;
        andar_borda = '0;
        prox_acima  = andar_q;
        prox_abaixo = andar_q;
        tem_acima   = 1'b0;
        for (int unsigned i = 0; i < N_ANDARES; i++) begin
            aqui_sel[i] = (W'(i) == andar_q);
            req_sel[i]  = (W'(i) == req_andar);
            acima[i]    = (W'(i) > andar_q);
            abaixo[i]   = (W'(i) < andar_q);
            if (s2_q[i]) andar_borda = W'(i);
            // ascending scan: last hit below is the nearest, first hit above is the nearest
            if (pend[i] && abaixo[i]) prox_abaixo = W'(i);
            if (pend[i] && acima[i] && !tem_acima) begin
                prox_acima = W'(i);
                tem_acima  = 1'b1;
            end
        end
        tem_abaixo = |(pend & abaixo);

        s2_multi   = (s2_q & (s2_q - UM)) != '0;
        s2_um      = (s2_q != '0) && !s2_multi;
        borda      = s2_q & ~s3_q;
        borda_ok   = s2_um && (borda != '0);
        pend_aqui  = |(pend & aqui_sel);
        pend_borda = |(pend & s2_q);

        req_ok     = req_valid && (|req_sel) && (estado_q != OCIOSO);
        req_ruim   = req_valid && !req_ok;
        fim_espera = (estado_q == ESPERA) && (cnt_q == CNT_ULT) && !emergencia;

        // clear first so a same-cycle request for this floor keeps its bit
        pend_coloca_d = pend_coloca_q;
        pend_tira_d   = pend_tira_q;
        if (fim_espera) begin
            pend_coloca_d = pend_coloca_d & ~aqui_sel;
            pend_tira_d   = pend_tira_d & ~aqui_sel;
        end
        if (req_ok) begin
            if (req_carga) pend_coloca_d = pend_coloca_d | req_sel;
            else           pend_tira_d   = pend_tira_d | req_sel;
        end

        if (pend_aqui || (pend == '0)) prox = andar_q;
        else if (sentido_q)            prox = tem_acima ? prox_acima : prox_abaixo;
        else                           prox = tem_abaixo ? prox_abaixo : prox_acima;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q      <= OCIOSO;
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
            pend_coloca_q <= '0;
            pend_tira_q   <= '0;
            andar_q       <= '0;
            sentido_q     <= 1'b1;
            cnt_q         <= '0;
            req_erro_q    <= 1'b0;
            sensor_erro_q <= 1'b0;
        end else begin
            s1_q          <= sensores;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            pend_coloca_q <= pend_coloca_d;
            pend_tira_q   <= pend_tira_d;
            req_erro_q    <= req_ruim;
            if (s2_multi) sensor_erro_q <= 1'b1;

            if (estado_q != OCIOSO && emergencia) begin
                estado_q <= EMERGENCIA;
            end else begin
                case (estado_q)
                    OCIOSO: if (iniciar) estado_q <= HOMING;
                    HOMING: if (s2_q[0]) begin
                        andar_q   <= '0;
                        sentido_q <= 1'b1;
                        estado_q  <= PARADO;
                    end
                    PARADO: begin
                        if (pend_aqui) begin
                            estado_q <= ESPERA;
                            cnt_q    <= '0;
                        end else if (sentido_q ? tem_acima : tem_abaixo) begin
                            estado_q <= sentido_q ? SUBINDO : DESCENDO;
                        end else if (tem_acima || tem_abaixo) begin
                            sentido_q <= ~sentido_q;
                            estado_q  <= sentido_q ? DESCENDO : SUBINDO;
                        end
                    end
                    SUBINDO, DESCENDO: if (borda_ok) begin
                        andar_q <= andar_borda;
                        if (pend_borda) begin
                            estado_q <= ESPERA;
                            cnt_q    <= '0;
                        end else if ((estado_q == SUBINDO  && andar_borda == TOPO) ||
                                     (estado_q == DESCENDO && andar_borda == '0)) begin
                            estado_q <= PARADO;
                        end
                    end
                    ESPERA: begin
                        if (cnt_q == CNT_ULT) estado_q <= PARADO;
                        else                  cnt_q    <= cnt_q + CW'(1);
                    end
                    EMERGENCIA: if (!emergencia) estado_q <= HOMING;
                    default: estado_q <= OCIOSO;
                endcase
            end
        end
    end

    always_comb begin
        motor_subindo  = (estado_q == SUBINDO);
        motor_descendo = (estado_q == HOMING) || (estado_q == DESCENDO);
        coloca_objetos = (estado_q == ESPERA) && |(pend_coloca_q & aqui_sel);
        tira_objetos   = (estado_q == ESPERA) && |(pend_tira_q & aqui_sel);
        andar_atual    = andar_q;
        prox_parada    = prox;
        tem_destino    = |pend;
        req_erro       = req_erro_q;
        sensor_erro    = sensor_erro_q;
        estado_db      = estado_q;
    end

endmodule

// File: tb/tb_smart_cargo_movimento_n.sv
// Randomised bench for smart_cargo_movimento_n: a simple shaft plant drives the
// floor sensors from the motor outputs, and a cycle model predicts every output.
module tb_smart_cargo_movimento_n;

    localparam int N  = 8;
    localparam int WW = 4;
    localparam int T  = 4;
    localparam int L  = 12;

    logic          clock = 1'b0;
    logic          reset, iniciar, emergencia, req_valid, req_carga;
    logic [N-1:0]  sensores;
    logic [WW-1:0] req_andar;
    logic          motor_subindo, motor_descendo, coloca_objetos, tira_objetos;
    logic [WW-1:0] andar_atual, prox_parada;
    logic          tem_destino, req_erro, sensor_erro;
    logic [2:0]    estado_db;

    always #5 clock = ~clock;

    smart_cargo_movimento_n #(.N_ANDARES(N), .W(WW), .T_ESPERA(T)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .emergencia(emergencia),
        .sensores(sensores), .req_valid(req_valid), .req_andar(req_andar),
        .req_carga(req_carga), .motor_subindo(motor_subindo),
        .motor_descendo(motor_descendo), .coloca_objetos(coloca_objetos),
        .tira_objetos(tira_objetos), .andar_atual(andar_atual),
        .prox_parada(prox_parada), .tem_destino(tem_destino), .req_erro(req_erro),
        .sensor_erro(sensor_erro), .estado_db(estado_db)
    );

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string nome, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", nome, got, exp, $time);
        end
    endtask

    // reference model: state codes 0..6 as named in the controller description
    int       ms, ma, mcnt;
    bit       msen, merr, mrq;
    bit [N-1:0] mc, mt, h1, h2, h3;

    task automatic model_reset();
        ms = 0; ma = 0; mcnt = 0; msen = 1'b1; merr = 1'b0; mrq = 1'b0;
        mc = '0; mt = '0; h1 = '0; h2 = '0; h3 = '0;
    endtask

    function automatic int nearest(input bit up, input int a, input bit [N-1:0] p);
        if (up) begin
            for (int i = a + 1; i < N; i++) if (p[i]) return i;
        end else begin
            for (int i = a - 1; i >= 0; i--) if (p[i]) return i;
        end
        return -1;
    endfunction

    function automatic int exp_prox();
        bit [N-1:0] p;
        int f;
        p = mc | mt;
        if (p == '0 || p[ma]) return ma;
        f = nearest(msen, ma, p);
        if (f < 0) f = nearest(!msen, ma, p);
        return f;
    endfunction

    task automatic model_step();
        bit [N-1:0] p, seen, prv, nc, nt;
        int ns, f;
        bit fin, ok;
        p = mc | mt; seen = h2; prv = h3; ns = ms;
        h3 = h2; h2 = h1; h1 = sensores;
        if ($countones(seen) > 1) merr = 1'b1;
        ok  = req_valid && (int'(req_andar) < N) && (ms != 0);
        mrq = req_valid && !ok;
        fin = (ms == 5) && (mcnt == T - 1) && !emergencia;
        nc = mc; nt = mt;
        if (fin) begin nc[ma] = 1'b0; nt[ma] = 1'b0; end
        if (ok) begin
            if (req_carga) nc[req_andar] = 1'b1;
            else           nt[req_andar] = 1'b1;
        end
        if (ms != 0 && emergencia) ns = 6;
        else case (ms)
            0: if (iniciar) ns = 1;
            1: if (seen[0]) begin ma = 0; msen = 1'b1; ns = 2; end
            2: begin
                if (p[ma]) begin ns = 5; mcnt = 0; end
                else if (nearest(msen, ma, p) >= 0) ns = msen ? 3 : 4;
                else if (nearest(!msen, ma, p) >= 0) begin
                    msen = !msen; ns = msen ? 3 : 4;
                end
            end
            3, 4: if ($countones(seen) == 1 && (seen & ~prv) != '0) begin
                f = 0;
                for (int i = 0; i < N; i++) if (seen[i]) f = i;
                ma = f;
                if (p[f]) begin ns = 5; mcnt = 0; end
                else if ((ms == 3 && f == N - 1) || (ms == 4 && f == 0)) ns = 2;
            end
            5: if (mcnt == T - 1) ns = 2; else mcnt++;
            6: if (!emergencia) ns = 1;
            default: ns = 0;
        endcase
        ms = ns; mc = nc; mt = nt;
    endtask

    task automatic check_all();
        cmp("motor", int'({motor_subindo, motor_descendo}), int'({ms == 3, (ms == 1 || ms == 4)}));
        cmp("acao", int'({coloca_objetos, tira_objetos}), int'({ms == 5 && mc[ma], ms == 5 && mt[ma]}));
        cmp("andar", int'(andar_atual), ma);
        cmp("prox", int'(prox_parada), exp_prox());
        cmp("flags", int'({tem_destino, req_erro, sensor_erro}), int'({(mc | mt) != '0, mrq, merr}));
        cmp("estado", int'(estado_db), ms);
    endtask

    // shaft plant: position in ticks, floor i sensed within +-2 ticks of i*L
    int pos;
    bit multi_on = 1'b0;

    task automatic plant();
        if (motor_subindo && pos < (N - 1) * L + 2 && $urandom_range(0, 3) != 0) pos++;
        else if (motor_descendo && pos > -2 && $urandom_range(0, 3) != 0) pos--;
        sensores = '0;
        for (int i = 0; i < N; i++)
            if (pos >= i * L - 2 && pos <= i * L + 2) sensores[i] = 1'b1;
        if (multi_on) sensores = 8'b0000_0110;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset(); else model_step();
        #1;
        check_all();
        req_valid = 1'b0;
        plant();
    endtask

    task automatic wait_state(input int code, input int budget);
        int n;
        n = 0;
        while (int'(estado_db) != code && n < budget) begin tick(); n++; end
        cmp("wait_estado", int'(estado_db), code);
    endtask

    task automatic pedir(input int andar, input bit carga);
        req_valid = 1'b1; req_andar = WW'(andar); req_carga = carga;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, emer_left;
        reset = 1'b1; iniciar = 1'b0; emergencia = 1'b0; req_valid = 1'b0;
        req_carga = 1'b0; req_andar = '0; pos = L;
        model_reset();
        plant();
        tick(); tick();
        cmp("rst_estado", int'(estado_db), 0);
        cmp("rst_prox", int'(prox_parada), 0);
        cmp("rst_motor", int'({motor_subindo, motor_descendo}), 0);
        cmp("rst_andar", int'(andar_atual), 0);
        reset = 1'b0;
        tick();

        // requests are refused while idle
        pedir(3, 1'b1);
        cmp("erro_ocioso", int'(req_erro), 1);
        cmp("ocioso_sem_destino", int'(tem_destino), 0);
        tick();
        cmp("erro_pulso", int'(req_erro), 0);

        // homing from floor 1 down to floor 0
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        cmp("homing_estado", int'(estado_db), 1);
        cmp("homing_motor", int'(motor_descendo), 1);
        wait_state(2, 300);
        cmp("homing_andar", int'(andar_atual), 0);

        pedir(9, 1'b1);
        cmp("erro_fora", int'(req_erro), 1);
        cmp("fora_sem_destino", int'(tem_destino), 0);

        // load at floor 5, dwell length
        pedir(5, 1'b1);
        wait_state(5, 500);
        cmp("andar5", int'(andar_atual), 5);
        cmp("coloca5", int'(coloca_objetos), 1);
        n = 0;
        while (estado_db == 3'd5 && n < 20) begin n++; tick(); end
        cmp("dwell_len", n, T);
        cmp("pend5_limpo", int'(tem_destino), 0);

        // SCAN: 7 served before 2
        pedir(7, 1'b1);
        pedir(2, 1'b0);
        cmp("scan_estado", int'(estado_db), 3);
        cmp("scan_prox", int'(prox_parada), 7);
        wait_state(5, 500);
        cmp("andar7", int'(andar_atual), 7);
        cmp("coloca7", int'(coloca_objetos), 1);
        wait_state(4, 50);
        wait_state(5, 800);
        cmp("andar2", int'(andar_atual), 2);
        cmp("tira2", int'(tira_objetos), 1);
        wait_state(2, 50);

        // emergency while climbing
        pedir(6, 1'b1);
        wait_state(3, 50);
        repeat (5) tick();
        emergencia = 1'b1;
        tick();
        cmp("emerg_motor", int'({motor_subindo, motor_descendo}), 0);
        cmp("emerg_estado", int'(estado_db), 6);
        repeat (3) tick();
        emergencia = 1'b0;
        tick();
        cmp("emerg_homing", int'(estado_db), 1);
        cmp("emerg_pend", int'(tem_destino), 1);
        wait_state(5, 3000);
        cmp("andar6", int'(andar_atual), 6);
        wait_state(2, 50);

        // multi-hot sensors between floors while descending
        pedir(1, 1'b0);
        wait_state(4, 50);
        n = 0;
        while (sensores != '0 && n < 50) begin tick(); n++; end
        multi_on = 1'b1;
        sensores = 8'b0000_0110;
        repeat (4) tick();
        multi_on = 1'b0;
        cmp("sensor_erro", int'(sensor_erro), 1);
        cmp("multi_andar", int'(andar_atual), 6);
        wait_state(5, 3000);
        cmp("andar1", int'(andar_atual), 1);
        cmp("tira1", int'(tira_objetos), 1);
        wait_state(2, 50);

        // asynchronous reset during a dwell
        pedir(4, 1'b1);
        wait_state(5, 2000);
        tick();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        cmp("arst_estado", int'(estado_db), 0);
        cmp("arst_saidas", int'({motor_subindo, motor_descendo, coloca_objetos, tira_objetos,
                                 tem_destino, req_erro, sensor_erro}), 0);
        cmp("arst_andar", int'(andar_atual), 0);
        cmp("arst_prox", int'(prox_parada), 0);
        tick();
        reset = 1'b0;

        // random traffic
        iniciar = 1'b1;
        emer_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (emer_left > 0) begin emergencia = 1'b1; emer_left--; end
            else emergencia = 1'b0;
            if ($urandom_range(0, 399) == 0) emer_left = $urandom_range(1, 8);
            if ($urandom_range(0, 5) == 0) begin
                req_valid = 1'b1;
                req_andar = WW'($urandom_range(0, 9));
                req_carga = $urandom_range(0, 1) != 0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smart_cargo_movimento_n.md
# smart_cargo_movimento_n

Parametrised movement controller for the SmartCargo elevator, generalising the fixed 4-floor movement path to `N_ANDARES` floors. It keeps separate load and unload request bitmaps and schedules stops with a SCAN (continue-in-direction) policy. It drives the up/down motor outputs, runs a timed dwell at each stop with `coloca_objetos`/`tira_objetos` asserted, and handles homing and emergency stop. It sits between the serial request decoder (upstream, supplies `req_*`) and the motor/display outputs in the top level.

## Interface
- `N_ANDARES`, default 8: number of floors, ≥2.
- `W`, default `$clog2(N_ANDARES)`: floor index width.
- `T_ESPERA`, default 50_000_000: dwell length in clock cycles, ≥1.

- `clock`  in  1  single system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `iniciar`  in  1  level; starts homing from OCIOSO.
- `emergencia`  in  1  level; forces EMERGENCIA.
- `sensores`  in  N_ANDARES  floor sensors, active-high (already inverted), one-hot when at a floor.
- `req_valid`  in  1  one-cycle request strobe.
- `req_andar`  in  W  requested floor.
- `req_carga`  in  1  1 = load (coloca), 0 = unload (tira).
- `motor_subindo`  out  1  motor up.
- `motor_descendo`  out  1  motor down.
- `coloca_objetos`  out  1  load action active during dwell.
- `tira_objetos`  out  1  unload action active during dwell.
- `andar_atual`  out  W  last confirmed floor.
- `prox_parada`  out  W  next scheduled stop.
- `tem_destino`  out  1  any request pending.
- `req_erro`  out  1  one-cycle pulse when a request is rejected.
- `sensor_erro`  out  1  sticky flag for multi-hot sensors.
- `estado_db`  out  3  state code.

## Operation
- States and codes: OCIOSO=0, HOMING=1, PARADO=2, SUBINDO=3, DESCENDO=4, ESPERA=5, EMERGENCIA=6.
- Motor outputs are Moore, decoded from state: `motor_descendo` in HOMING/DESCENDO; `motor_subindo` in SUBINDO.
- Sensors: `sensores` passes through a 2-flop synchroniser (s1, s2) plus a delay stage (s3). A floor edge is `s2 & ~s3`. Updates to `andar_atual` use only a one-hot `s2`. Multi-hot `s2` sets `sensor_erro` and that edge is ignored.
- Requests:
  - `req_valid` with `req_andar < N_ANDARES` sets `pend_coloca[req_andar]` or `pend_tira[req_andar]`, selected by `req_carga`.
  - A request is accepted in every state except OCIOSO.
  - Out-of-range requests, and any request in OCIOSO, pulse `req_erro` in the next cycle and change nothing.
- Let `pend = pend_coloca | pend_tira`; `tem_destino = |pend`.
- `sentido` register (1 = up) holds the scan direction.
- OCIOSO: `iniciar` → HOMING.
- HOMING: when `s2[0]` is high (level), set `andar_atual = 0`, `sentido = 1`, go to PARADO.
- PARADO, evaluated in this priority order:
  1. `pend[andar_atual]` → ESPERA.
  2. Pending floor exists in the `sentido` direction → continue that way (SUBINDO or DESCENDO).
  3. Otherwise, pending floor exists in the opposite direction → flip `sentido` and move.
  4. Otherwise stay in PARADO.
- SUBINDO/DESCENDO: on a valid floor edge at floor f:
  - `andar_atual ← f`.
  - If `pend[f]` → ESPERA.
  - Else if f = N_ANDARES-1 (up) or f = 0 (down) → PARADO.
- ESPERA:
  - Counter loads 0 on entry and counts to `T_ESPERA-1`.
  - `coloca_objetos = pend_coloca[andar_atual]` and `tira_objetos = pend_tira[andar_atual]` throughout the dwell.
  - On the final count, clear both bits for `andar_atual` and go to PARADO.
  - A new request for the same floor and type arriving in that same cycle wins: the bit stays set.
- EMERGENCIA:
  - Entered from any non-OCIOSO state while `emergencia` is high; it has priority over all other transitions.
  - The dwell counter is abandoned and pending bits are kept.
  - When `emergencia` goes low → HOMING.
- `prox_parada`:
  - If `sentido` = 1: nearest pending floor > `andar_atual`, else nearest pending floor < `andar_atual`.
  - If `sentido` = 0: mirrored.
  - If `pend[andar_atual]` is set, or nothing is pending: `andar_atual`.
- Reset values: state OCIOSO; `andar_atual` 0; `sentido` 1; bitmaps, counter, synchroniser and `sensor_erro` 0. All outputs 0, with `prox_parada` = 0 and `estado_db` = 0.

## Timing
- A sensor bit that rises before edge 0 is seen as a floor edge between edges 1 and 2.
- At edge 2, `andar_atual` and the state update; motor outputs drop after edge 2.
- `iniciar` → HOMING (motor_descendo = 1) one edge later.
- `emergencia` high → motors low one edge later.
- ESPERA lasts exactly `T_ESPERA` cycles, then PARADO for at least one cycle before any motor start.
- A request to `andar_atual` while in PARADO: bitmap set at edge k, ESPERA at edge k+1.
- `reset` asserted mid-move clears everything immediately (asynchronous), including motors.

## Test plan
- N_ANDARES=8, T_ESPERA=4: `reset`, `iniciar`, assert `sensores[0]` → HOMING then PARADO; `andar_atual`=0, `estado_db`=2.
- Load request floor 5: drive sensor pulses for floors 1..5 → SUBINDO; `motor_subindo` drops 3 edges after `sensores[5]` rises; ESPERA for 4 cycles with `coloca_objetos`=1; `pend_coloca[5]` cleared after the dwell.
- At floor 5 going up, pending 2 (unload) and 7 (load) → `prox_parada`=7, stops at 7 first, then reverses to 2 with `tira_objetos`=1.
- `req_andar`=9 with N_ANDARES=8, and any request in OCIOSO → `req_erro` pulse, bitmaps unchanged.
- `emergencia` during SUBINDO → motors 0 next edge, `estado_db`=6; on release → HOMING; pending bits preserved and served afterwards.
- `sensores`=8'b0000_0110 during a move → `sensor_erro`=1 (sticky), `andar_atual` unchanged; async `reset` mid-ESPERA → all outputs 0 immediately.
